// File: rtl/r88_fetchseq.sv
// ---------------------------------------------------------------------------
// r88_fetchseq -- instruction fetch / execute sequencer for the R88 core.
//
// Fetches 1..3 instruction bytes from memory (address always taken from PC),
// then moves data between register-block entries over the shared internal
// bus intD.
//
// Instruction encoding:
//   00xxxxxx  NOP  1 byte
//   01xxxxxx  MOV  2 bytes, operand {dst[7:4], src[3:0]}
//   10xxdddd  LDI  2 bytes, dst = opcode[3:0], operand = immediate
//   11xxxxxx  JMP  3 bytes, operands PC lo then PC hi
//
// Ports:
//   sysClock    in     system clock, rising edge
//   sysReset    in     synchronous active-high reset
//   intD        inout  8-bit internal data bus, driven only in WR/WRH
//   regSel      out    register-block select (7/8 = PC lo/hi)
//   regRead     out    register-block read strobe
//   regWrite    out    register-block write strobe
//   incPC       out    PC increment strobe
//   regAddrSel  out    address source, constant 2 (PC)
//   memRead     out    memory read request (held in WAIT)
//   memReady    in     memory acknowledge, memData valid when high
//   memData     in     memory read data
//   opcode      out    last fetched opcode
//   instrDone   out    one-cycle retirement pulse
//   illegalOp   out    sticky illegal-select trap flag
//   dbgState    out    current FSM state, for observation only
//
// Build option:
//   R88_ILLEGAL_TRAP_EN  when defined, MOV/LDI with dst>10 or MOV src>11
//                        halts the sequencer with illegalOp set until reset.
//                        When undefined, illegalOp is tied low and such
//                        instructions execute normally.
//
// Handshake: memRead is a request held high every WAIT cycle; the byte is
// taken on the rising edge where memReady is sampled high during WAIT.
// memReady in any other state is ignored.
// ---------------------------------------------------------------------------
module r88_fetchseq (
    input  logic       sysClock,
    input  logic       sysReset,
    inout  wire  [7:0] intD,
    output logic [3:0] regSel,
    output logic       regRead,
    output logic       regWrite,
    output logic       incPC,
    output logic [1:0] regAddrSel,
    output logic       memRead,
    input  logic       memReady,
    input  logic [7:0] memData,
    output logic [7:0] opcode,
    output logic       instrDone,
    output logic       illegalOp,
    output logic [2:0] dbgState
);

    typedef enum logic [2:0] {
        S_ADDR = 3'd0,
        S_WAIT = 3'd1,
        S_INC  = 3'd2,
        S_RD1  = 3'd3,
        S_RD2  = 3'd4,
        S_WR   = 3'd5,
        S_WRH  = 3'd6,
        S_HALT = 3'd7
    } state_e;

    localparam logic [1:0] CLS_NOP = 2'd0;
    localparam logic [1:0] CLS_MOV = 2'd1;
    localparam logic [1:0] CLS_LDI = 2'd2;
    localparam logic [1:0] CLS_JMP = 2'd3;

    function automatic logic [1:0] instr_len(input logic [7:0] op);
        case (op[7:6])
            CLS_NOP: return 2'd1;
            CLS_JMP: return 2'd3;
            default: return 2'd2;
        endcase
    endfunction

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;       // index of the byte being fetched
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] op1_q, op1_d;       // first operand byte
    logic [7:0] op2_q, op2_d;       // second operand byte (JMP hi)
    logic [7:0] temp_q, temp_d;     // MOV source value captured in RD2

    logic [1:0] cls;
    logic       last_byte;

    assign cls       = opcode_q[7:6];
    // In INC, idx_q still names the byte just fetched.
    assign last_byte = (2'(idx_q + 2'd1) == instr_len(opcode_q));

`ifdef R88_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    logic trap_hit;

    // Evaluated in INC after the last byte, when every operand is captured.
    assign trap_hit = ((cls == CLS_MOV) && ((op1_q[7:4] > 4'd10) || (op1_q[3:0] > 4'd11)))
                   || ((cls == CLS_LDI) && (opcode_q[3:0] > 4'd10));
`endif

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge sysClock) begin
        if (sysReset) begin
            state_q  <= S_ADDR;
            idx_q    <= 2'd0;
            opcode_q <= 8'h00;
            op1_q    <= 8'h00;
            op2_q    <= 8'h00;
            temp_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            temp_q   <= temp_d;
        end
    end

`ifdef R88_ILLEGAL_TRAP_EN
    always_ff @(posedge sysClock) begin
        if (sysReset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        opcode_d = opcode_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        temp_d   = temp_q;
`ifdef R88_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif

        case (state_q)
            S_ADDR: state_d = S_WAIT;

            S_WAIT: begin
                if (memReady) begin
                    case (idx_q)
                        2'd0:    opcode_d = memData;
                        2'd1:    op1_d    = memData;
                        default: op2_d    = memData;
                    endcase
                    state_d = S_INC;
                end
            end

            S_INC: begin
                if (!last_byte) begin
                    idx_d   = 2'(idx_q + 2'd1);
                    state_d = S_ADDR;
                end else begin
                    idx_d = 2'd0;
                    case (cls)
                        CLS_NOP: state_d = S_ADDR;
                        CLS_MOV: state_d = S_RD1;
                        default: state_d = S_WR;
                    endcase
`ifdef R88_ILLEGAL_TRAP_EN
                    if (trap_hit) begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
`endif
                end
            end

            S_RD1: state_d = S_RD2;

            S_RD2: begin
                temp_d  = intD;
                state_d = S_WR;
            end

            S_WR:  state_d = (cls == CLS_JMP) ? S_WRH : S_ADDR;

            S_WRH: state_d = S_ADDR;

            default: state_d = S_HALT;   // HALT: left only through reset
        endcase
    end

    // ---------------------------------------------------------------------
    // Output decode
    // ---------------------------------------------------------------------
    logic       mem_rd, reg_rd, reg_wr, inc_pc, done, drive_en;
    logic [3:0] sel;
    logic [7:0] wr_data;

    always_comb begin
        mem_rd   = 1'b0;
        reg_rd   = 1'b0;
        reg_wr   = 1'b0;
        inc_pc   = 1'b0;
        done     = 1'b0;
        drive_en = 1'b0;
        sel      = 4'd0;
        wr_data  = 8'h00;

        case (state_q)
            S_WAIT: mem_rd = 1'b1;

            S_INC: begin
                inc_pc = 1'b1;
                done   = last_byte && (cls == CLS_NOP);
            end

            S_RD1, S_RD2: begin
                reg_rd = 1'b1;
                sel    = op1_q[3:0];
            end

            S_WR: begin
                reg_wr   = 1'b1;
                drive_en = 1'b1;
                done     = (cls != CLS_JMP);
                case (cls)
                    CLS_MOV: begin
                        sel     = op1_q[7:4];
                        wr_data = temp_q;
                    end
                    CLS_LDI: begin
                        sel     = opcode_q[3:0];
                        wr_data = op1_q;
                    end
                    default: begin
                        sel     = 4'd7;
                        wr_data = op1_q;
                    end
                endcase
            end

            S_WRH: begin
                reg_wr   = 1'b1;
                drive_en = 1'b1;
                done     = 1'b1;
                sel      = 4'd8;
                wr_data  = op2_q;
            end

            default: ;
        endcase

        // Reset takes effect on the outputs in the cycle it is raised, so an
        // aborted instruction cannot issue a request, write or PC increment.
        if (sysReset) begin
            mem_rd   = 1'b0;
            reg_rd   = 1'b0;
            reg_wr   = 1'b0;
            inc_pc   = 1'b0;
            done     = 1'b0;
            drive_en = 1'b0;
            sel      = 4'd0;
        end
    end

    assign intD       = drive_en ? wr_data : 8'hzz;
    assign regSel     = sel;
    assign regRead    = reg_rd;
    assign regWrite   = reg_wr;
    assign incPC      = inc_pc;
    assign regAddrSel = 2'd2;
    assign memRead    = mem_rd;
    assign opcode     = opcode_q;
    assign instrDone  = done;
    assign dbgState   = state_q;

`ifdef R88_ILLEGAL_TRAP_EN
    assign illegalOp = illegal_q;
`else
    assign illegalOp = 1'b0;
`endif

endmodule

// File: tb/tb_r88_fetchseq.sv
// ---------------------------------------------------------------------------
// Bench for r88_fetchseq. Acts as memory and register block, and predicts
// per instruction: retirement cycle, opcode, register reads/writes and PC
// increments, from the encoding and per-byte fetch cost.
// ---------------------------------------------------------------------------
module tb_r88_fetchseq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    wire  [7:0] int_d;
    logic [3:0] reg_sel;
    logic       reg_read, reg_write, inc_pc;
    logic [1:0] reg_addr_sel;
    logic       mem_read;
    logic       mem_ready = 1'b0;
    logic [7:0] mem_data  = 8'h00;
    logic [7:0] opcode;
    logic       instr_done, illegal_op;
    logic [2:0] dbg_state;

    logic       tb_rd_valid = 1'b0;
    logic [7:0] tb_drv_val  = 8'h00;
    // register block answers reads combinationally
    assign int_d = (reg_read && tb_rd_valid) ? tb_drv_val : 8'hzz;

    r88_fetchseq dut (
        .sysClock   (clk),
        .sysReset   (rst),
        .intD       (int_d),
        .regSel     (reg_sel),
        .regRead    (reg_read),
        .regWrite   (reg_write),
        .incPC      (inc_pc),
        .regAddrSel (reg_addr_sel),
        .memRead    (mem_read),
        .memReady   (mem_ready),
        .memData    (mem_data),
        .opcode     (opcode),
        .instrDone  (instr_done),
        .illegalOp  (illegal_op),
        .dbgState   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  byte_q[$];       // memory byte stream
    int          wait_q[$];       // wait states per byte
    logic [7:0]  rd_q[$];         // value returned for each MOV source read
    logic [11:0] exp_wr_q[$];     // {sel, data} expected writes
    logic [3:0]  exp_rd_q[$];     // expected select per read cycle
    int          exp_done_cyc_q[$];
    logic [7:0]  exp_done_op_q[$];

    int t_next;       // cycle number at which the next instruction starts
    int exp_inc;
    int inc_seen;
    int cyc;
    int strobe_bad      = 0;
    int addr_bad        = 0;
    int memread_in_rst  = 0;
    bit in_fetch        = 1'b0;
    int wait_left       = 0;
    int rd_cnt          = 0;

    // Reference model: each byte costs ADDR + WAIT(1 + waits) + INC.
    task automatic add_instr(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2,
                             input int w0, input int w1, input int w2, input logic [7:0] rdv);
        int len;
        int cost;
        int tail;
        len  = (op[7:6] == 2'd0) ? 1 : (op[7:6] == 2'd3) ? 3 : 2;
        cost = 3 + w0;
        byte_q.push_back(op);
        wait_q.push_back(w0);
        if (len >= 2) begin
            byte_q.push_back(b1);
            wait_q.push_back(w1);
            cost += 3 + w1;
        end
        if (len == 3) begin
            byte_q.push_back(b2);
            wait_q.push_back(w2);
            cost += 3 + w2;
        end
        tail = 0;
        case (op[7:6])
            2'd1: begin
                tail = 3;
                exp_rd_q.push_back(b1[3:0]);
                exp_rd_q.push_back(b1[3:0]);
                rd_q.push_back(rdv);
                exp_wr_q.push_back({b1[7:4], rdv});
            end
            2'd2: begin
                tail = 1;
                exp_wr_q.push_back({op[3:0], b1});
            end
            2'd3: begin
                tail = 2;
                exp_wr_q.push_back({4'd7, b1});
                exp_wr_q.push_back({4'd8, b2});
            end
            default: tail = 0;
        endcase
        exp_done_cyc_q.push_back(t_next + cost + tail - 1);
        exp_done_op_q.push_back(op);
        t_next  += cost + tail;
        exp_inc += len;
    endtask

    // ---------------- memory / register-block responder + monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            cyc       = 0;
            in_fetch  = 1'b0;
            rd_cnt    = 0;
            mem_ready = 1'b0;
            if (mem_read) memread_in_rst++;
        end else begin
            cyc++;
            if ((int'(reg_read) + int'(reg_write) + int'(inc_pc)) > 1) strobe_bad++;
            if (reg_addr_sel != 2'd2) addr_bad++;
            if (inc_pc) inc_seen++;

            if (reg_read) begin
                if (exp_rd_q.size() == 0) check_eq("unexpected_read", 32'(reg_sel), 32'hFFFF);
                else check_eq("read_sel", 32'(reg_sel), 32'(exp_rd_q.pop_front()));
                rd_cnt++;
            end else if (rd_cnt >= 2) begin
                if (rd_q.size() > 0) void'(rd_q.pop_front());
                rd_cnt = 0;
            end

            if (reg_write) begin
                if (exp_wr_q.size() == 0) check_eq("unexpected_write", 32'({reg_sel, int_d}), 32'hFFFF);
                else check_eq("write_sel_data", 32'({reg_sel, int_d}), 32'(exp_wr_q.pop_front()));
            end

            if (instr_done) begin
                if (exp_done_cyc_q.size() == 0) begin
                    check_eq("unexpected_done", 32'(cyc), 32'hFFFF);
                end else begin
                    check_eq("done_cycle", 32'(cyc), 32'(exp_done_cyc_q.pop_front()));
                    check_eq("done_opcode", 32'(opcode), 32'(exp_done_op_q.pop_front()));
                end
            end

            if (mem_read) begin
                if (!in_fetch) begin
                    in_fetch  = 1'b1;
                    wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 1000000;
                end
                if (wait_left == 0 && byte_q.size() > 0) begin
                    mem_ready = 1'b1;
                    mem_data  = byte_q.pop_front();
                    in_fetch  = 1'b0;
                end else begin
                    mem_ready = 1'b0;
                    mem_data  = 8'($urandom);
                    if (wait_left > 0) wait_left--;
                end
            end else begin
                // noise outside WAIT must be ignored
                mem_ready = 1'($urandom_range(0, 1));
                mem_data  = 8'($urandom);
            end
        end
        tb_rd_valid = (rd_q.size() > 0);
        tb_drv_val  = (rd_q.size() > 0) ? rd_q[0] : 8'h00;
    end

    // ---------------- driver tasks ----------------
    task automatic start_prog();
        @(posedge clk);
        #1 rst = 1'b1;
        byte_q.delete();
        wait_q.delete();
        rd_q.delete();
        exp_wr_q.delete();
        exp_rd_q.delete();
        exp_done_cyc_q.delete();
        exp_done_op_q.delete();
        t_next   = 1;
        exp_inc  = 0;
        inc_seen = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_prog(input string tag, input int budget);
        int n;
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        while (exp_done_cyc_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_eq({tag, "_pending_done"}, 32'(exp_done_cyc_q.size()), 32'd0);
        check_eq({tag, "_pending_writes"}, 32'(exp_wr_q.size()), 32'd0);
        check_eq({tag, "_inc_count"}, 32'(inc_seen), 32'(exp_inc));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_memread"}, 32'(mem_read), 32'd0);
        check_eq({tag, "_strobes"}, 32'({reg_read, reg_write, inc_pc, instr_done}), 32'd0);
        check_eq({tag, "_regsel"}, 32'(reg_sel), 32'd0);
        check_eq({tag, "_opcode"}, 32'(opcode), 32'd0);
        check_eq({tag, "_illegal"}, 32'(illegal_op), 32'd0);
        check_eq({tag, "_addrsel"}, 32'(reg_addr_sel), 32'd2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // NOP stream, zero wait
        start_prog();
        check_reset_state("por");
        add_instr(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        add_instr(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        add_instr(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        run_prog("nop", 200);

        // LDI A,0x5A
        start_prog();
        add_instr(8'h80, 8'h5A, 8'h00, 0, 0, 0, 8'h00);
        run_prog("ldi", 200);

        // MOV B<-C with register value 0x77
        start_prog();
        add_instr(8'h40, 8'h12, 8'h00, 0, 0, 0, 8'h77);
        run_prog("mov", 200);

        // JMP 0x1234 with two wait states per byte
        start_prog();
        add_instr(8'hC0, 8'h34, 8'h12, 2, 2, 2, 8'h00);
        run_prog("jmp", 200);

        // MOV with src == dst still reads and writes
        start_prog();
        add_instr(8'h55, 8'h33, 8'h00, 1, 0, 0, 8'hA5);
        run_prog("mov_same", 200);

        // randomized mix
        start_prog();
        for (int i = 0; i < 40; i++) begin
            logic [7:0] op, b1, b2;
            op = 8'($urandom);
            b1 = 8'($urandom);
            b2 = 8'($urandom);
`ifdef R88_ILLEGAL_TRAP_EN
            if (op[7:6] == 2'd1) b1 = {4'($urandom_range(0, 10)), 4'($urandom_range(0, 11))};
            if (op[7:6] == 2'd2) op[3:0] = 4'($urandom_range(0, 10));
`endif
            add_instr(op, b1, b2, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), 8'($urandom));
        end
        run_prog("random", 3000);

        // reset clears state after activity
        start_prog();
        check_reset_state("rst_after_run");

        // reset during the second WAIT cycle of an operand fetch
        byte_q.push_back(8'h85);
        byte_q.push_back(8'h33);
        wait_q.push_back(0);
        wait_q.push_back(5);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("abort_memread_before", 32'(mem_read), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("abort_memread_same_cycle", 32'(mem_read), 32'd0);
        @(posedge clk);
        #1;
        check_eq("abort_memread_next", 32'(mem_read), 32'd0);
        check_eq("abort_no_write", 32'(reg_write), 32'd0);
        check_eq("abort_no_inc", 32'(inc_pc), 32'd0);
        check_eq("abort_inc_count", 32'(inc_seen), 32'd1);
        start_prog();
        add_instr(8'h3F, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        run_prog("restart", 200);

        // out-of-range destination
        start_prog();
`ifdef R88_ILLEGAL_TRAP_EN
        byte_q.push_back(8'h8F);
        byte_q.push_back(8'h00);
        wait_q.push_back(0);
        wait_q.push_back(0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (26) @(posedge clk);
        #1;
        check_eq("trap_flag", 32'(illegal_op), 32'd1);
        check_eq("trap_halt_strobes", 32'({mem_read, reg_read, reg_write, inc_pc}), 32'd0);
        check_eq("trap_inc_count", 32'(inc_seen), 32'd2);
        start_prog();
        check_eq("trap_cleared", 32'(illegal_op), 32'd0);
`else
        add_instr(8'h8F, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        run_prog("bad_dst", 200);
        check_eq("no_trap_flag", 32'(illegal_op), 32'd0);
`endif

        check_eq("strobe_exclusive", 32'(strobe_bad), 32'd0);
        check_eq("addrsel_const", 32'(addr_bad), 32'd0);
        check_eq("memread_in_reset", 32'(memread_in_rst), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
